// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared slice width and FSM state type for rca_seq
package rca_seq_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - 3-bit ripple-carry adder shared by the rca_seq slice loop
module rca
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/rca_seq.sv
// rtl/rca_seq.sv - multi-cycle WIDTH-bit adder built from one shared 3-bit rca
module rca_seq
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  if (WIDTH <= 0 || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("rca_seq: WIDTH must be a positive multiple of 3");
  end

  rca_seq_state_t     state, state_nxt;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   a_reg, b_reg, result;
  logic               carry_reg;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last_slice;

  assign last_slice = (k == KW'(NUM_SLICES - 1));

  // Operands shift down each RUN cycle so the current slice is always at bit 0.
  rca u_rca (
    .a    (a_reg[SLICE_W-1:0]),
    .b    (b_reg[SLICE_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice sums enter at the top of result and shift down, landing in place after the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            result    <= '0;
            k         <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> SLICE_W;
          b_reg     <= b_reg >> SLICE_W;
          result    <= (result >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));
          carry_reg <= slice_cout;
          k         <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = result;
  assign out_cout = carry_reg;

endmodule

// File: tb/tb_rca_seq.sv
// tb/tb_rca_seq.sv - directed and swept self-checking bench for rca_seq
module tb_rca_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_cout;

  int n_checks = 0;
  int n_fail   = 0;

  rca_seq #(.WIDTH(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, then presents operands across exactly one accepting edge.
  task automatic accept(input logic [11:0] a, input logic [11:0] b, input logic c);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~c;
  endtask

  task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                        input logic c, input int stall);
    logic [12:0] ref_sum;
    int lat;
    ref_sum = {1'b0, a} + {1'b0, b} + {12'd0, c};
    accept(a, b, c);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  lat, 4);
    check({tag, "_sum"},  {20'd0, out_sum}, {20'd0, ref_sum[11:0]});
    check({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ref_sum[12]});
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = (i == 1);
      in_a = 12'h0AA; in_b = 12'h055; in_cin = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_hold_sum"},   {19'd0, out_cout, out_sum}, {19'd0, ref_sum});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc, nacc, npulse, c1, c2;
    logic pre;
    logic [11:0] ra, rb;
    logic rc;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   {20'd0, out_sum}, 32'd0);
    check("rst_out_cout",  {31'd0, out_cout}, 32'd0);
    @(posedge clk); #1;

    run_op("fff_p_001", 12'hFFF, 12'h001, 1'b0, 0);
    check("fff_p_001_const", {19'd0, 1'b1, 12'h000}, {19'd0, 13'h1000});
    run_op("5a3_p_2c4", 12'h5A3, 12'h2C4, 1'b1, 0);
    run_op("bp_123_456", 12'h123, 12'h456, 1'b0, 5);

    // Reset in the middle of RUN.
    accept(12'hFFF, 12'hFFF, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum",   {20'd0, out_sum}, 32'd0);
    check("mid_rst_cout",  {31'd0, out_cout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    run_op("post_rst_007", 12'h007, 12'h001, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high.
    in_a = 12'h800; in_b = 12'h800; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; nacc = 0; npulse = 0; c1 = 0; c2 = 0;
    while (npulse < 2 && cyc < 40) begin
      pre = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (pre) begin
        nacc++;
        if (nacc == 1) begin in_a = 12'h001; in_b = 12'h002; end
      end
      if (out_valid) begin
        if (npulse == 0) begin
          c1 = cyc;
          check("b2b_0_sum", {19'd0, out_cout, out_sum}, 32'h1000);
        end else begin
          c2 = cyc;
          check("b2b_1_sum", {19'd0, out_cout, out_sum}, 32'h0003);
          in_valid = 1'b0;
        end
        npulse++;
      end
    end
    in_valid = 1'b0;
    check("b2b_pulses",  npulse, 2);
    check("b2b_spacing", c2 - c1, 6);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_idle", {31'd0, in_ready}, 32'd1);

    // Random sweep with random output stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rc = 1'($urandom);
      run_op("rand", ra, rb, rc, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
